// File: rtl/sev_seg_pkg.sv
// Shared constants and helpers for the seven-segment display multiplexer.
// Segment patterns are active-high, ordered {A,B,C,D,E,F,G} with A in the MSB.
package sev_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

  function automatic int idx_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/sev_seg_hex.sv
// Hex digit to active-high seven-segment pattern decoder (purely combinational).
module sev_seg_hex
  import sev_seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  assign pattern = SEG_PATTERNS[code];

endmodule

// File: rtl/sev_seg_mux.sv
// Time-multiplexed N-digit seven-segment driver with frame-aligned updates.
// Optional leading-zero blanking is enabled by defining SEV_SEG_MUX_LZB_EN.
module sev_seg_mux
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int BLANK_CYCLES   = 50,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
`ifdef SEV_SEG_MUX_LZB_EN
  input  logic                    blank_lz,
`endif
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_start
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic                  DP_IDLE  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] DIG_IDLE = DIG_ACTIVE_LOW ? '1 : '0;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pend_digits;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_valid;
  logic [4*NUM_DIGITS-1:0] act_digits;
  logic [NUM_DIGITS-1:0]   act_dp;

  logic                    slot_end;
  logic                    frame_wrap;
  logic                    in_blank;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [6:0]              cur_pattern;

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);
  assign in_blank   = (cnt < BLANK_END);

`ifdef SEV_SEG_MUX_LZB_EN
  // Blank from the top digit down while code and dp are both zero; digit 0 always shows.
  always_comb begin
    logic lz_run;
    lz_mask = '0;
    // NOTE: blocking assignments here build a ripple chain evaluated in loop order
    // within one combinational pass; non-blocking would read stale values.
    lz_run  = blank_lz;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run     = lz_run && (act_digits[4*i +: 4] == 4'h0) && !act_dp[i];
      lz_mask[i] = lz_run;
    end
  end
`else
  assign lz_mask = '0;
`endif

  // Compare idx against each position instead of indexing, so no slice can go out of range.
  always_comb begin
    cur_code  = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    onehot    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_code  = act_digits[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_blank = lz_mask[i];
        onehot[i] = 1'b1;
      end
    end
  end

  sev_seg_hex u_hex (
    .code    (cur_code),
    .pattern (cur_pattern)
  );

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the pre-edge values, matching real flip-flop behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_valid  <= 1'b0;
      act_digits  <= '0;
      act_dp      <= '0;
      seg         <= SEG_IDLE;
      dp          <= DP_IDLE;
      dig_en      <= DIG_IDLE;
      frame_start <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (load) begin
        pend_digits <= digits;
        pend_dp     <= dp_in;
      end

      // A load on the wrap cycle goes straight to the active buffer.
      if (frame_wrap) begin
        if (load) begin
          act_digits <= digits;
          act_dp     <= dp_in;
        end else if (pend_valid) begin
          act_digits <= pend_digits;
          act_dp     <= pend_dp;
        end
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_valid <= 1'b1;
      end

      frame_start <= frame_wrap;

      if (in_blank) begin
        seg    <= SEG_IDLE;
        dp     <= DP_IDLE;
        dig_en <= DIG_IDLE;
      end else begin
        dig_en <= DIG_ACTIVE_LOW ? ~onehot : onehot;
        if (cur_blank) begin
          seg <= SEG_IDLE;
          dp  <= DP_IDLE;
        end else begin
          seg <= SEG_ACTIVE_LOW ? ~cur_pattern : cur_pattern;
          dp  <= cur_dp ^ SEG_ACTIVE_LOW;
        end
      end
    end
  end

endmodule

// File: doc/sev_seg_mux.md
Name: sev_seg_mux

Overview:
Time-multiplexed driver for an N-digit common-cathode/anode seven-segment display on the D2 clock board.
- Accepts packed 4-bit digit codes plus decimal points and buffers them, so updates take effect only at frame boundaries.
- Cycles one digit enable at a time with a programmable dwell and an anti-ghosting blank window.
- Decodes full hex (0-F), unlike the earlier decimal-only decoder.
- Sits between the timekeeping core and the board pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 1000, clk cycles per digit slot (>= 2).
- BLANK_CYCLES, 50, cycles at the start of each slot with all digits off (0 <= BLANK_CYCLES < REFRESH_DIV).
- SEG_ACTIVE_LOW, 1, 1 = segment/dp outputs are active-low.
- DIG_ACTIVE_LOW, 1, 1 = digit enables are active-low.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- digits  input  4*NUM_DIGITS  packed codes; digit 0 = digits[3:0] = rightmost.
- dp_in  input  NUM_DIGITS  decimal point per digit.
- load  input  1  capture digits/dp_in into pending buffer this cycle.
- seg  output  7  segments {A,B,C,D,E,F,G}, MSB = A.
- dp  output  1  decimal point of currently driven digit.
- dig_en  output  NUM_DIGITS  one-hot (or all-off) digit enables.
- frame_start  output  1  one-cycle pulse when slot index wraps to 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - cnt = 0, idx = 0.
  - pending and active buffers = 0; pending_valid = 0.
  - seg = all inactive (7'b1111111 when SEG_ACTIVE_LOW).
  - dp inactive, dig_en all inactive, frame_start = 0.
- Refresh counter:
  - cnt counts 0..REFRESH_DIV-1.
  - At cnt == REFRESH_DIV-1: cnt <= 0 and idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1.
- Frame wrap: the cycle where idx goes NUM_DIGITS-1 -> 0.
  - frame_start asserts for one cycle.
  - If pending_valid, active <= pending and pending_valid <= 0.
- Load:
  - load = 1 captures pending <= {digits, dp_in} and sets pending_valid <= 1.
  - Repeated loads within a frame: last one wins.
  - load coincident with a frame wrap bypasses pending: active <= inputs this cycle, and pending_valid is cleared.
- Output timing: all outputs are registered. Outputs in cycle t+1 reflect idx, cnt and active in cycle t (1-cycle latency).
- Slot outputs:
  - cnt < BLANK_CYCLES: dig_en all inactive, seg/dp inactive.
  - Otherwise: dig_en[idx] active only; seg = decode(active digit idx); dp = active dp[idx]; polarities applied per parameters.
- Decode (active-high pattern ABCDEFG, inverted when SEG_ACTIVE_LOW):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Reset mid-frame: immediate return to reset state. A pending load is discarded.
- Never more than one dig_en bit active in any cycle.

Optional Feature:
- Macro SEV_SEG_MUX_LZB_EN: leading-zero blanking, adds input port blank_lz (1 bit).
- With the macro and blank_lz = 1: scanning from digit NUM_DIGITS-1 downward, digits whose code is 0 and whose dp is 0 are blanked (seg and dp inactive, dig_en still driven) until the first nonzero code or set dp. Digit 0 is never blanked.
- Without the macro: no blank_lz port, all digits are always displayed.
- Blank mask is computed from the active buffer, so it also changes only at frame boundaries.

Decomposition:
- sev_seg_pkg holds:
  - the 16-entry active-high segment pattern constants;
  - the SEG_OFF constant;
  - the localparam function for the idx width, clog2(NUM_DIGITS).
- One combinational sub-module, sev_seg_hex (4-bit code -> 7-bit active-high pattern), instantiated once on the muxed digit.
- Polarity inversion and the output registers stay in sev_seg_mux.

Test Plan:
All cases use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, active-low.
1. Reset then idle: seg = 7'b1111111, dig_en = 4'b1111, frame_start = 0 during reset and the cycle after.
2. load digits = 16'h1234, dp_in = 0 then wait 2 frames: slot order dig_en = 1110, 1101, 1011, 0111. Segments show 4, 3, 2, 1 (4 -> 7'b1001100). All-off for 1 cycle at each slot start.
3. load 16'hABCD mid-frame: the display keeps the old value until the next frame_start. Next frame shows D, C, B, A (A -> 7'b0001000).
4. Loads of 16'h1111 then 16'h2222 in the same frame: only 2222 is displayed next frame. A load on the frame-wrap cycle takes effect in that same frame.
5. Assert rst mid-slot with a pending load: outputs go inactive next cycle. After release the display shows 0000, not the discarded load.
6. Macro defined, blank_lz = 1, digits = 16'h0050, dp_in = 0: digit 3 and digit 2 have seg inactive, digit 1 shows 5, digit 0 shows 0. With dp_in = 4'b1000, all four digits are shown.
